// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache that sits
// between the MEM stage and a 256-bit-line main memory.
//
// Ports
//   clk_i, rst_i         clock (rising edge), asynchronous active-low reset
//   p1_addr_i/_data_i    CPU byte address and store data
//   p1_MemRead_i/Write_i CPU load/store request (both set = store)
//   p1_data_o            load data, valid while p1_stall_o is low
//   p1_stall_o           freezes the pipeline during a miss
//   mem_*                line-wide enable/ack handshake to main memory
//   hit_cnt_o/miss_cnt_o hit/miss statistics (only with DCACHE_STATS_EN)
//
// Optional feature macro: DCACHE_STATS_EN adds the statistics counters.
module dcache_ctrl #(
  parameter int LINES = 32,
  parameter int TAG_W = 22
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_e;
  state_e state_q, state_d;

  // Line storage, all in flops. Tags/data need no reset: valid gates them.
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [255:0]     data_q [LINES];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] idx;
  logic [2:0]       word;
  logic [255:0]     line;
  logic [31:0]      rd_word;
  logic             req, hit, store_hit, fill;

  assign req_tag = p1_addr_i[31 -: TAG_W];
  assign idx     = p1_addr_i[5 +: IDX_W];
  assign word    = p1_addr_i[4:2];
  assign line    = data_q[idx];
  assign rd_word = line[{word, 5'b0} +: 32];

  assign req = p1_MemRead_i | p1_MemWrite_i;
  assign hit = valid_q[idx] & (tag_q[idx] == req_tag);

  // Stores merge only in IDLE; in REFILL the line already hits but the
  // request is completed one cycle later, back in IDLE.
  assign store_hit = (state_q == IDLE) & req & hit & p1_MemWrite_i;
  assign fill      = (state_q == ALLOCATE) & mem_ack_i;

  // Byte offset bits are never used by a word-granular cache.
  logic unused_addr;
  assign unused_addr = &{1'b0, p1_addr_i[1:0]};

  // Loads see the (pre-store) word combinationally on a hit.
  assign p1_data_o = (req & hit) ? rd_word : '0;

  always_comb begin
    state_d      = state_q;
    p1_stall_o   = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      IDLE: begin
        if (req & ~hit) begin
          p1_stall_o = 1'b1;
          state_d    = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx], idx, 5'b0};
        mem_data_o   = line;
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, 5'b0};
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        p1_stall_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[idx]  <= req_tag;
      data_q[idx] <= mem_data_i;
    end else if (store_hit) begin
      data_q[idx][{word, 5'b0} +: 32] <= p1_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  // The completion cycle after REFILL is the tail of a miss, not a hit.
  logic prev_refill_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prev_refill_q <= 1'b0;
      hit_cnt_o     <= '0;
      miss_cnt_o    <= '0;
    end else begin
      prev_refill_q <= (state_q == REFILL);
      if (state_q == IDLE && state_d != IDLE)
        miss_cnt_o <= miss_cnt_o + 32'd1;
      if (state_q == IDLE && req && !p1_stall_o && !prev_refill_q)
        hit_cnt_o <= hit_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl. The reference treats the cache as a
// transparent flat memory (word-addressed golden store) plus a directory of
// which line sits at each index, from which hit/miss, stall length and the
// expected memory traffic follow.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  p1_addr_i = '0, p1_data_i = '0;
  logic         p1_MemRead_i = 1'b0, p1_MemWrite_i = 1'b0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_enable_o, mem_write_o;
  logic         ack_r = 1'b0, spur = 1'b0;
  logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

  assign mem_ack_i = ack_r | spur;

  dcache_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;

  // ---------------- main memory + golden view ----------------
  logic [255:0] bmem [int unsigned];   // backing store, by line address
  logic [31:0]  gold [int unsigned];   // what a CPU load must see, by word

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  function automatic logic [255:0] back_line(input int unsigned la);
    logic [255:0] l;
    logic [31:0]  base;
    if (bmem.exists(la)) return bmem[la];
    base = la << 5;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(base + 32'(i*4));
    return l;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    if (gold.exists(k)) return gold[k];
    return init_word({a[31:2], 2'b00});
  endfunction

  function automatic logic [255:0] gold_line(input int unsigned la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = gold_rd((la << 5) + 32'(i*4));
    return l;
  endfunction

  // Directory of resident lines.
  bit          mv [32];
  bit          md [32];
  int unsigned ml [32];

  // ---------------- memory responder ----------------
  int wdly = 0, rdly = 0, cnt = 0;
  int wb_cnt = 0, rf_cnt = 0;
  logic [31:0]  wb_addr = '0, rf_addr = '0;
  logic [255:0] wb_data = '0;

  always @(negedge clk) begin
    ack_r = 1'b0;
    if (!rst_i) cnt = 0;
    else if (mem_enable_o) begin
      if (cnt == (mem_write_o ? wdly : rdly)) begin
        ack_r = 1'b1;
        cnt = 0;
        if (mem_write_o) begin
          bmem[mem_addr_o >> 5] = mem_data_o;
          wb_cnt++; wb_addr = mem_addr_o; wb_data = mem_data_o;
        end else begin
          mem_data_i = back_line(mem_addr_o >> 5);
          rf_cnt++; rf_addr = mem_addr_o;
        end
      end else cnt++;
    end else cnt = 0;
  end

  // Reset drops any dirty data the cache held; the golden view reverts to
  // what main memory holds.
  task automatic model_reset();
    logic [255:0] l;
    for (int i = 0; i < 32; i++) begin
      if (mv[i] && md[i]) begin
        l = back_line(ml[i]);
        for (int w = 0; w < 8; w++) gold[ml[i]*8 + w] = l[w*32 +: 32];
      end
      mv[i] = 0; md[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    #3;
    @(posedge clk); #1;
    rst_i = 1'b1;
    model_reset();
  endtask

  // One CPU access, entered and left just after a rising edge.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int nw, input int nr);
    int idx, exp_stall, stalls, wb0, rf0;
    int unsigned la, victim;
    bit miss, dirty_ev;
    logic [31:0] exp_d;
    logic [255:0] exp_line;
    idx = int'(a[9:5]);
    la = a >> 5;
    miss = !(mv[idx] && ml[idx] == la);
    dirty_ev = miss && mv[idx] && md[idx];
    victim = ml[idx];
    exp_stall = !miss ? 0 : (dirty_ev ? nw + nr + 4 : nr + 3);
    exp_d = gold_rd(a);
    exp_line = gold_line(victim);
    wdly = nw; rdly = nr; wb0 = wb_cnt; rf0 = rf_cnt;
    p1_addr_i = a; p1_data_i = d; p1_MemRead_i = rd; p1_MemWrite_i = wr;
    stalls = 0;
    @(negedge clk);
    while (p1_stall_o && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    total_cnt++;
    if (stalls !== exp_stall)
      $display("FAIL stall_len a=%h got %0d exp %0d", a, stalls, exp_stall);
    else pass_cnt++;
    if (rd) begin
      total_cnt++;
      if (p1_data_o !== exp_d)
        $display("FAIL load_data a=%h got %h exp %h", a, p1_data_o, exp_d);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    total_cnt++;
    if ((wb_cnt - wb0) !== int'(dirty_ev) || (rf_cnt - rf0) !== int'(miss))
      $display("FAIL traffic a=%h got wb=%0d rf=%0d exp wb=%0d rf=%0d",
               a, wb_cnt - wb0, rf_cnt - rf0, dirty_ev, miss);
    else pass_cnt++;
    if (miss) begin
      total_cnt++;
      if (rf_addr !== (la << 5))
        $display("FAIL refill_addr got %h exp %h", rf_addr, la << 5);
      else pass_cnt++;
    end
    if (dirty_ev) begin
      total_cnt++;
      if (wb_addr !== (victim << 5) || wb_data !== exp_line)
        $display("FAIL writeback got %h/%h exp %h/%h", wb_addr, wb_data, victim << 5, exp_line);
      else pass_cnt++;
    end
    if (miss) begin mv[idx] = 1; md[idx] = 0; ml[idx] = la; end
    if (wr) begin gold[a >> 2] = d; md[idx] = 1; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst_i = 1'b0;
    #12;
    total_cnt++;
    if ({mem_enable_o, mem_write_o, p1_stall_o} !== 3'b000 || mem_addr_o !== '0 ||
        mem_data_o !== '0 || p1_data_o !== '0)
      $display("FAIL reset_outputs got en=%b wr=%b st=%b addr=%h dout=%h exp all zero",
               mem_enable_o, mem_write_o, p1_stall_o, mem_addr_o, p1_data_o);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_i = 1'b1;
    model_reset();
  endtask

  task automatic test_reset_mid_miss();
    access(1, 0, 32'h80, 0, 0, 1);
    wdly = 0; rdly = 20;
    p1_addr_i = 32'h1080; p1_MemRead_i = 1'b1;   // same index, clean victim
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h1080)
      $display("FAIL alloc_req got en=%b wr=%b addr=%h exp 1 0 00001080",
               mem_enable_o, mem_write_o, mem_addr_o);
    else pass_cnt++;
    rst_i = 1'b0;
    #1;
    total_cnt++;
    if (mem_enable_o !== 1'b0)
      $display("FAIL async_abort got en=%b exp 0", mem_enable_o);
    else pass_cnt++;
    p1_MemRead_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    model_reset();
    access(1, 0, 32'h80, 0, 0, 2);   // must miss again
  endtask

  task automatic test_directed();
    access(1, 0, 32'h40, 0, 0, 2);
    access(0, 1, 32'h44, 32'hDEADBEEF, 0, 0);
    access(1, 0, 32'h44, 0, 0, 0);
    access(1, 0, 32'h444, 0, 2, 3);
    total_cnt++;
    if (wb_addr !== 32'h40 || wb_data[63:32] !== 32'hDEADBEEF)
      $display("FAIL wb_deadbeef got %h/%h exp 00000040/deadbeef", wb_addr, wb_data[63:32]);
    else pass_cnt++;
  endtask

  task automatic test_ack_delays();
    access(1, 0, 32'h200, 0, 0, 0);
    access(1, 0, 32'h220, 0, 0, 1);
    access(1, 0, 32'h240, 0, 0, 7);
    access(0, 1, 32'h20C, 32'h1234_5678, 0, 0);
    access(1, 0, 32'h600, 0, 7, 0);   // dirty victim 0x200
    access(1, 1, 32'h604, 32'hCAFE_F00D, 0, 0);  // both set: store, pre-store data
    access(1, 0, 32'h204, 0, 0, 0);   // dirty victim 0x600, zero delays
    access(1, 0, 32'h20C, 0, 0, 0);
  endtask

  task automatic test_spurious_ack();
    mem_data_i = {8{32'hBAD0_BAD0}};
    spur = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (mem_enable_o !== 1'b0 || p1_stall_o !== 1'b0)
      $display("FAIL spurious_ack got en=%b st=%b exp 0 0", mem_enable_o, p1_stall_o);
    else pass_cnt++;
    @(posedge clk); #1;
    spur = 1'b0;
    access(1, 0, 32'h204, 0, 0, 0);   // still resident, unchanged
  endtask

  task automatic test_random();
    logic [31:0] a;
    int op;
    for (int n = 0; n < 80; n++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
          (32'($urandom_range(0, 7)) << 2);
      op = int'($urandom_range(0, 2));
      access(op != 1, op != 0, a, $urandom, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)));
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    do_reset();
    total_cnt++;
    if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0)
      $display("FAIL stats_reset got %0d/%0d exp 0/0", hit_cnt_o, miss_cnt_o);
    else pass_cnt++;
    access(1, 0, 32'h100, 0, 0, 1);
    access(0, 1, 32'h104, 32'h5555_AAAA, 0, 0);
    access(1, 0, 32'h100, 0, 0, 0);
    access(1, 0, 32'h500, 0, 1, 1);
    total_cnt++;
    if (hit_cnt_o !== 32'd2 || miss_cnt_o !== 32'd2)
      $display("FAIL stats_count got hit=%0d miss=%0d exp 2 2", hit_cnt_o, miss_cnt_o);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_miss();
    test_directed();
    test_ack_delays();
    test_spurious_ack();
    test_random();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage (EX_MEM outputs) and a slow 256-bit-line main memory. It replaces the flat single-cycle data memory. Hits complete in the same cycle. Misses hold `p1_stall_o` high while a dirty victim is written back and the line is refilled through an enable/ack handshake. The pipeline freezes every stage while stalled.

## Interface
Parameters:
- `LINES`, 32: number of cache lines (power of two); index width is log2(LINES).
- `TAG_W`, 22: tag width; equals 32 - log2(LINES) - 5.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `p1_addr_i` in 32: byte address; [4:2] word select, [1:0] ignored.
- `p1_data_i` in 32: store data.
- `p1_MemRead_i` in 1: load request.
- `p1_MemWrite_i` in 1: store request.
- `p1_data_o` out 32: load data, valid when `p1_stall_o`=0.
- `p1_stall_o` out 1: freeze pipeline.
- `mem_addr_o` out 32: line address, [4:0]=0.
- `mem_data_o` out 256: write-back line.
- `mem_data_i` in 256: refill line.
- `mem_enable_o` out 1: memory request.
- `mem_write_o` out 1: 1=write-back, 0=refill.
- `mem_ack_i` in 1: single-cycle completion pulse.

## Operation
- Address split: tag=[31:32-TAG_W], index=[4+log2(LINES):5], word=[4:2].
- Per-line storage: valid, dirty, tag, and 256-bit data, all held in flops.
- `req` = MemRead | MemWrite. If both are set, the request is a store, and `p1_data_o` returns the pre-store word.
- `hit` = valid[index] & (tag[index] == addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL.
  - IDLE, `req & hit`: store writes the word into the line at the clock edge and sets dirty. Load drives the word on `p1_data_o` combinationally.
  - IDLE, `req & ~hit`: go to WRITEBACK if the victim is valid and dirty, else to ALLOCATE.
  - WRITEBACK: `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={victim tag, index, 5'b0}, `mem_data_o`=victim line. On `mem_ack_i`, go to ALLOCATE.
  - ALLOCATE: `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={req tag, index, 5'b0}. On `mem_ack_i`, load `mem_data_i` into the line, set valid=1, dirty=0, write the tag, and go to REFILL.
  - REFILL: one cycle, then IDLE. The request now hits and completes as a normal hit; a store merges then and sets dirty.
- Stall rule:
  - IDLE: `p1_stall_o` = `req & ~hit` (combinational).
  - WRITEBACK, ALLOCATE, REFILL: `p1_stall_o`=1.
- While stalled, CPU inputs are stable. Input changes mid-miss are not supported.
- `mem_ack_i` outside WRITEBACK or ALLOCATE is ignored.

## Timing
- Reset values: state IDLE; all valid and dirty bits 0; `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `p1_data_o`=0. `p1_stall_o`=0 unless `req` is asserted.
- Hit latency: 0 cycles; the load result appears in the same cycle as the request.
- Clean miss, ack arriving N cycles after enable rises:
  - stall lasts N+3 cycles: 1 in IDLE, N+1 in ALLOCATE, 1 in REFILL;
  - completion happens in the following IDLE cycle.
- Dirty miss: stall lasts Nw+Nr+4 cycles.
- Handshake: `mem_enable_o` rises on the edge entering WRITEBACK or ALLOCATE. Address, data and write stay constant until the ack. Between WRITEBACK and ALLOCATE, `mem_enable_o` stays 1, but address and write change. `mem_enable_o` is 0 in the cycle after the ALLOCATE ack.
- Ack in the same cycle enable rises is legal (N=0).
- Reset mid-miss: abort immediately; `mem_enable_o` drops asynchronously, and all lines become invalid. The dirty victim is lost; this is accepted.
- Index conflicts (same index, different tag) evict the resident line. There is no index wrap concern, since the index is a bit-field.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `hit_cnt_o` (out, 32) and `miss_cnt_o` (out, 32), both reset to 0.
  - `miss_cnt_o` increments on each IDLE→WRITEBACK/ALLOCATE transition.
  - `hit_cnt_o` increments on each edge where `req & ~p1_stall_o` in IDLE, unless the previous state was REFILL.
  - Both counters wrap at 2^32.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- After reset, load from 0x0000_0040: stall for N+3 cycles. Memory sees exactly one refill with `mem_addr_o`=0x40 and `mem_write_o`=0. The word at [4:2]=0 is returned.
- Store 0xDEADBEEF to 0x44, then load 0x44: both hit with 0 stall; the load returns 0xDEADBEEF; no memory traffic.
- Load 0x0000_0444, which maps to the same index as 0x44 with a new tag:
  - first a write-back to 0x40, with 0xDEADBEEF at `mem_data_o`[63:32];
  - then a refill from 0x440;
  - stall lasts Nw+Nr+4 cycles.
- Assert `rst_i` low during ALLOCATE: `mem_enable_o` goes 0 immediately. The next access to the same line misses again.
- Ack delays of 0, 1 and 7 cycles give the correct stall lengths and data. A spurious `mem_ack_i` in IDLE has no effect.
- With `DCACHE_STATS_EN` defined: the sequence miss, hit, hit, dirty miss gives `hit_cnt_o`=2 and `miss_cnt_o`=2.
